arbitro_enrutamiento_param: RTL and testbench

Parametrised successor of the two-VC arbiter/router. It arbitrates among NUM_VC virtual-channel FIFOs and routes each granted word to one of NUM_DEST destination FIFOs, selected by the word's destination field. It sits between the VC FIFOs and the destination FIFOs of the transaction layer. It adds selectable fixed or round-robin priority, non-blocking skip of paused destinations, registered outputs with explicit push strobes, and per-destination word counters.

---
 rtl/arbitro_enrutamiento_param.sv | 110 +++++++++++
 tb/tb_arbitro_enrutamiento_param.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/arbitro_enrutamiento_param.sv
// Virtual-channel arbiter/router: picks one eligible VC FIFO head per cycle
// (fixed or round-robin priority) and forwards it, one cycle later, to the destination FIFO it names.
module arbitro_enrutamiento_param #(
  parameter int DATA_W   = 6,
  parameter int NUM_VC   = 2,
  parameter int NUM_DEST = 2,
  parameter int DEST_W   = $clog2(NUM_DEST),
  parameter int RR_MODE  = 0,
  parameter int CNT_W    = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_VC*DATA_W-1:0]     VC_data,
  input  logic [NUM_VC-1:0]            VC_empty,
  output logic [NUM_VC-1:0]            VC_pop,
  input  logic [NUM_DEST-1:0]          D_pause,
  output logic [NUM_DEST*DATA_W-1:0]   D_data,
  output logic [NUM_DEST-1:0]          D_push,
  output logic [NUM_DEST*CNT_W-1:0]    D_count,
  output logic                         idle
);

  localparam int IDX_W = $clog2(NUM_VC);

  function automatic logic [IDX_W-1:0] f_next_ptr(input logic [IDX_W-1:0] g);
    if (int'(g) == NUM_VC - 1) return '0;
    else return g + 1'b1;
  endfunction

  logic [DATA_W-1:0]   w_vc_word [NUM_VC];
  logic [DEST_W-1:0]   w_vc_dest [NUM_VC];
  logic [NUM_VC-1:0]   w_elig;
  logic                w_gnt_vld;
  logic [IDX_W-1:0]    w_gnt_idx;
  logic [DATA_W-1:0]   w_sel_word;
  logic [DEST_W-1:0]   w_sel_dest;
  logic [NUM_VC-1:0]   w_pop;

  logic [DATA_W-1:0]   r_d_data_p0  [NUM_DEST];
  logic [CNT_W-1:0]    r_d_count_p0 [NUM_DEST];
  logic [NUM_DEST-1:0] r_vld_p0;
  logic                r_idle_p0;
  logic [IDX_W-1:0]    r_ptr_p0;

  // A head is eligible only if its own destination can take it, so a
  // paused destination never stalls channels bound elsewhere.
  for (genvar i = 0; i < NUM_VC; i++) begin : g_vc
    assign w_vc_word[i] = VC_data[i*DATA_W +: DATA_W];
    assign w_vc_dest[i] = w_vc_word[i][DATA_W-1 -: DEST_W];
    assign w_elig[i]    = ~VC_empty[i] & ~D_pause[w_vc_dest[i]];
  end

  always_comb begin
    int v;
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    for (int k = 0; k < NUM_VC; k++) begin
      v = k;
      if (RR_MODE != 0) begin
        v = int'(r_ptr_p0) + k;
        if (v >= NUM_VC) v = v - NUM_VC;
      end
      if (!w_gnt_vld && w_elig[IDX_W'(v)]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = IDX_W'(v);
      end
    end
  end

  assign w_sel_word = w_vc_word[w_gnt_idx];
  assign w_sel_dest = w_vc_dest[w_gnt_idx];

  always_comb begin
    w_pop = '0;
    if (!reset && w_gnt_vld) w_pop[w_gnt_idx] = 1'b1;
  end

  assign VC_pop = w_pop;

  // ---- stage p0: granted word registered onto its destination ----
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld_p0  <= '0;
      r_idle_p0 <= 1'b1;
      r_ptr_p0  <= '0;
      for (int d = 0; d < NUM_DEST; d++) begin
        r_d_data_p0[d]  <= '0;
        r_d_count_p0[d] <= '0;
      end
    end else begin
      r_vld_p0  <= '0;
      r_idle_p0 <= ~w_gnt_vld;
      if (w_gnt_vld) begin
        r_vld_p0[w_sel_dest]     <= 1'b1;
        r_d_data_p0[w_sel_dest]  <= w_sel_word;
        r_d_count_p0[w_sel_dest] <= r_d_count_p0[w_sel_dest] + 1'b1;
        if (RR_MODE != 0) r_ptr_p0 <= f_next_ptr(w_gnt_idx);
      end
    end
  end

  for (genvar d = 0; d < NUM_DEST; d++) begin : g_dest
    assign D_data[d*DATA_W +: DATA_W] = r_d_data_p0[d];
    assign D_count[d*CNT_W +: CNT_W]  = r_d_count_p0[d];
  end

  assign D_push = r_vld_p0;
  assign idle   = r_idle_p0;

endmodule

// File: tb/tb_arbitro_enrutamiento_param.sv
// Scoreboard bench: a fixed-priority instance (CNT_W=2) and a round-robin
// instance, driven by directed vectors; pushes are checked by a separate monitor.
module tb_arbitro_enrutamiento_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [11:0] fx_vcd, rr_vcd;
  logic [1:0]  fx_emp, rr_emp, fx_pause, rr_pause;
  logic [1:0]  fx_pop, rr_pop, fx_push, rr_push;
  logic [11:0] fx_dd, rr_dd;
  logic [3:0]  fx_cnt;
  logic [15:0] rr_cnt;
  logic        fx_idle, rr_idle;

  arbitro_enrutamiento_param #(
    .DATA_W(6), .NUM_VC(2), .NUM_DEST(2), .RR_MODE(0), .CNT_W(2)
  ) u_fix (
    .clk(clk), .reset(reset), .VC_data(fx_vcd), .VC_empty(fx_emp),
    .VC_pop(fx_pop), .D_pause(fx_pause), .D_data(fx_dd), .D_push(fx_push),
    .D_count(fx_cnt), .idle(fx_idle)
  );

  arbitro_enrutamiento_param #(
    .DATA_W(6), .NUM_VC(2), .NUM_DEST(2), .RR_MODE(1), .CNT_W(8)
  ) u_rr (
    .clk(clk), .reset(reset), .VC_data(rr_vcd), .VC_empty(rr_emp),
    .VC_pop(rr_pop), .D_pause(rr_pause), .D_data(rr_dd), .D_push(rr_push),
    .D_count(rr_cnt), .idle(rr_idle)
  );

  typedef struct {
    logic       dest;
    logic [5:0] data;
    logic [7:0] cnt;
  } exp_t;

  exp_t       q_fix[$];
  exp_t       q_rr[$];
  logic [5:0] last_fx [2];
  logic [5:0] last_rr [2];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // One stimulus cycle: drive one instance, check its pop, queue the expected push.
  task automatic step(input bit rr, input logic [5:0] d0, input logic [5:0] d1,
                      input logic [1:0] emp, input logic [1:0] pause,
                      input logic [1:0] exp_pop, input logic dest, input logic [7:0] cnt);
    exp_t e;
    @(negedge clk);
    if (rr) begin
      rr_vcd = {d1, d0}; rr_emp = emp; rr_pause = pause;
      fx_emp = 2'b11;    fx_pause = 2'b00;
    end else begin
      fx_vcd = {d1, d0}; fx_emp = emp; fx_pause = pause;
      rr_emp = 2'b11;    rr_pause = 2'b00;
    end
    #1;
    if (rr) chk("rr_pop", rr_pop, exp_pop);
    else    chk("fx_pop", fx_pop, exp_pop);
    if (exp_pop != 2'b00) begin
      e.dest = dest;
      e.data = (exp_pop == 2'b01) ? d0 : d1;
      e.cnt  = cnt;
      if (rr) q_rr.push_back(e);
      else    q_fix.push_back(e);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset  = 1'b1;
    fx_vcd = {6'b100011, 6'b000101}; fx_emp = 2'b10; fx_pause = 2'b00;
    rr_vcd = {6'b100011, 6'b000101}; rr_emp = 2'b10; rr_pause = 2'b00;
    for (int j = 0; j < 2; j++) begin
      last_fx[j] = '0;
      last_rr[j] = '0;
    end
    for (int c = 0; c < 2; c++) begin
      #1;
      chk("rst_fx_pop", fx_pop, 2'b00);
      chk("rst_rr_pop", rr_pop, 2'b00);
      @(negedge clk);
      chk("rst_fx_push", fx_push, 2'b00);
      chk("rst_fx_data", fx_dd, 12'h000);
      chk("rst_fx_count", fx_cnt, 4'h0);
      chk("rst_fx_idle", fx_idle, 1'b1);
      chk("rst_rr_push", rr_push, 2'b00);
      chk("rst_rr_count", rr_cnt, 16'h0000);
      chk("rst_rr_idle", rr_idle, 1'b1);
    end
    reset  = 1'b0;
    fx_emp = 2'b11;
    rr_emp = 2'b11;
  endtask

  // Monitor: every registered push must match the head of its queue.
  always @(negedge clk) begin
    exp_t e;
    logic o;
    if (fx_push !== 2'b00) begin
      if (q_fix.size() == 0) begin
        checks++; errors++;
        $display("FAIL fx_unexpected_push actual=%b expected=00", fx_push);
      end else begin
        e = q_fix.pop_front();
        o = ~e.dest;
        chk("fx_push", fx_push, 2'b01 << e.dest);
        chk("fx_data", fx_dd[e.dest*6 +: 6], e.data);
        chk("fx_count", fx_cnt[e.dest*2 +: 2], e.cnt[1:0]);
        chk("fx_hold", fx_dd[o*6 +: 6], last_fx[o]);
        last_fx[e.dest] = e.data;
      end
    end
    chk("fx_idle", fx_idle, (fx_push == 2'b00));
    if (rr_push !== 2'b00) begin
      if (q_rr.size() == 0) begin
        checks++; errors++;
        $display("FAIL rr_unexpected_push actual=%b expected=00", rr_push);
      end else begin
        e = q_rr.pop_front();
        o = ~e.dest;
        chk("rr_push", rr_push, 2'b01 << e.dest);
        chk("rr_data", rr_dd[e.dest*6 +: 6], e.data);
        chk("rr_count", rr_cnt[e.dest*8 +: 8], e.cnt);
        chk("rr_hold", rr_dd[o*6 +: 6], last_rr[o]);
        last_rr[e.dest] = e.data;
      end
    end
    chk("rr_idle", rr_idle, (rr_push == 2'b00));
  end

  initial begin
    reset  = 1'b1;
    fx_vcd = '0; fx_emp = 2'b11; fx_pause = 2'b00;
    rr_vcd = '0; rr_emp = 2'b11; rr_pause = 2'b00;
    do_reset();

    // Fixed priority: both ready, VC0 wins
    step(0, 6'b000101, 6'b100011, 2'b00, 2'b00, 2'b01, 1'b0, 8'd1);
    // VC0 bound for paused dest 1, VC1 proceeds
    step(0, 6'b100001, 6'b000111, 2'b00, 2'b10, 2'b10, 1'b0, 8'd2);
    step(0, 6'b100001, 6'b000111, 2'b10, 2'b10, 2'b00, 1'b0, 8'd0);
    step(0, 6'b100001, 6'b000111, 2'b10, 2'b00, 2'b01, 1'b1, 8'd1);
    // Pause rising in the push cycle does not cancel that push
    step(0, 6'b100010, 6'b000000, 2'b10, 2'b00, 2'b01, 1'b1, 8'd2);
    step(0, 6'b100100, 6'b000000, 2'b10, 2'b10, 2'b00, 1'b0, 8'd0);
    step(0, 6'b100100, 6'b111000, 2'b00, 2'b10, 2'b00, 1'b0, 8'd0);
    step(0, 6'b000000, 6'b000000, 2'b11, 2'b00, 2'b00, 1'b0, 8'd0);
    step(0, 6'b000000, 6'b000000, 2'b11, 2'b00, 2'b00, 1'b0, 8'd0);

    // Counter wrap with CNT_W=2: 1,2,3,0,1
    do_reset();
    step(0, 6'b000001, 6'b000010, 2'b00, 2'b00, 2'b01, 1'b0, 8'd1);
    step(0, 6'b000011, 6'b000010, 2'b00, 2'b00, 2'b01, 1'b0, 8'd2);
    step(0, 6'b011111, 6'b000010, 2'b01, 2'b00, 2'b10, 1'b0, 8'd3);
    step(0, 6'b001100, 6'b010101, 2'b01, 2'b00, 2'b10, 1'b0, 8'd0);
    step(0, 6'b100000, 6'b011000, 2'b00, 2'b10, 2'b10, 1'b0, 8'd1);
    step(0, 6'b000000, 6'b000000, 2'b11, 2'b00, 2'b00, 1'b0, 8'd0);

    // Round-robin: alternating grants with both channels always ready
    step(1, 6'b000001, 6'b100001, 2'b00, 2'b00, 2'b01, 1'b0, 8'd1);
    step(1, 6'b000001, 6'b100001, 2'b00, 2'b00, 2'b10, 1'b1, 8'd1);
    step(1, 6'b000001, 6'b100001, 2'b00, 2'b00, 2'b01, 1'b0, 8'd2);
    step(1, 6'b000001, 6'b100001, 2'b00, 2'b00, 2'b10, 1'b1, 8'd2);
    step(1, 6'b000001, 6'b100001, 2'b00, 2'b00, 2'b01, 1'b0, 8'd3);
    step(1, 6'b000001, 6'b100001, 2'b00, 2'b00, 2'b10, 1'b1, 8'd3);
    // Pointer at VC0 but its destination is paused: VC1 goes
    step(1, 6'b100111, 6'b000110, 2'b00, 2'b10, 2'b10, 1'b0, 8'd4);
    step(1, 6'b100111, 6'b000110, 2'b00, 2'b00, 2'b01, 1'b1, 8'd4);
    step(1, 6'b000001, 6'b100001, 2'b00, 2'b00, 2'b10, 1'b1, 8'd5);
    step(1, 6'b000000, 6'b000011, 2'b01, 2'b00, 2'b10, 1'b0, 8'd5);
    step(1, 6'b000000, 6'b000000, 2'b11, 2'b00, 2'b00, 1'b0, 8'd0);

    repeat (3) @(negedge clk);
    #1;
    chk("fx_queue_drained", q_fix.size(), 0);
    chk("rr_queue_drained", q_rr.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
